// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants and helpers for the pipeline controller
//   Exception codes, stall vector patterns, FSM state encodings and the
//   stall-request priority encoder used by pipe_ctrl.
package pipe_ctrl_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [31:0] EXC_INTERRUPT = 32'h0000_0001;
    localparam logic [31:0] EXC_ERET      = 32'h0000_000e;

    // Bit order: [5]=wb [4]=mem [3]=ex [2]=id [1]=if [0]=pc
    localparam logic [5:0] STALL_MEM  = {NO_STOP, STOP,    STOP,    STOP,    STOP,    STOP};
    localparam logic [5:0] STALL_EX   = {NO_STOP, NO_STOP, STOP,    STOP,    STOP,    STOP};
    localparam logic [5:0] STALL_ID   = {NO_STOP, NO_STOP, NO_STOP, STOP,    STOP,    STOP};
    localparam logic [5:0] STALL_IF   = {NO_STOP, NO_STOP, NO_STOP, NO_STOP, STOP,    STOP};
    localparam logic [5:0] STALL_NONE = {6{NO_STOP}};

    localparam logic [0:0] CTRL_RUN  = 1'b0;
    localparam logic [0:0] CTRL_COOL = 1'b1;

    // The deepest requesting stage wins: it freezes itself and everything upstream.
    function automatic logic [5:0] stall_pattern(input logic req_if, input logic req_id,
                                                 input logic req_ex, input logic req_mem);
        if (req_mem)     return STALL_MEM;
        else if (req_ex) return STALL_EX;
        else if (req_id) return STALL_ID;
        else if (req_if) return STALL_IF;
        else             return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - pipeline <-> controller stall/flush bundle
//   master: pipeline side (drives stall requests and exception info, consumes stall/flush/new_pc)
//   slave : controller side (pipe_ctrl)
interface pipe_ctrl_if;
    logic        stallreq_from_if;
    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        stallreq_from_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;

    modport master (
        output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        output excepttype_i, cp0_epc_i,
        input  stall, flush, new_pc
    );

    modport slave (
        input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        input  excepttype_i, cp0_epc_i,
        output stall, flush, new_pc
    );
endinterface

// File: rtl/pipe_ctrl_satcnt.sv
// rtl/pipe_ctrl_satcnt.sv - saturating up-counter with async active-low clear
//   i_clk   : clock
//   i_clr_n : asynchronous clear, active low
//   i_inc   : increment this cycle
//   o_count : current count, holds at all-ones
module pipe_ctrl_satcnt #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_clr_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);
    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n)
            r_count <= '0;
        else if (i_inc && (r_count != {W{1'b1}}))
            r_count <= r_count + 1'b1;
    end

    assign o_count = r_count;
endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - five-stage pipeline stall/flush controller
//   clk, rst      : clock, asynchronous active-low reset
//   bus (slave)   : stall requests, exception type, EPC in; stall vector, flush, new_pc out
//   stall_timeout : sticky watchdog flag for excessively long stall runs
//   stall_cnt_o   : saturating count of cycles with the PC stalled
//   flush_cnt_o   : saturating count of exception flushes
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] INT_VECTOR  = 32'h0000_0020,
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0040,
    parameter int          STALL_LIMIT = 16,
    parameter int          STALL_CNT_W = 32,
    parameter int          FLUSH_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    pipe_ctrl_if.slave             bus,
    output logic                   stall_timeout,
    output logic [STALL_CNT_W-1:0] stall_cnt_o,
    output logic [FLUSH_CNT_W-1:0] flush_cnt_o
);
    localparam int RUN_W = $clog2(STALL_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_LIMIT);

    logic [0:0]       r_state;
    logic [RUN_W-1:0] r_run_cnt;
    logic             r_stall_timeout;

    logic             w_exc_take;
    logic [5:0]       w_stall;
    logic             w_flush;
    logic [31:0]      w_new_pc;
    logic             w_run_active;
    logic [RUN_W-1:0] w_run_next;

    // rst gates the take so combinational outputs are quiet while held in reset.
    assign w_exc_take = rst && (r_state == CTRL_RUN) && (bus.excepttype_i != 32'h0);

    always_comb begin
        w_stall  = STALL_NONE;
        w_flush  = 1'b0;
        w_new_pc = 32'h0;
        if (rst) begin
            if (w_exc_take) begin
                w_flush = 1'b1;
                if (bus.excepttype_i == EXC_INTERRUPT)
                    w_new_pc = INT_VECTOR;
                else if (bus.excepttype_i == EXC_ERET)
                    w_new_pc = bus.cp0_epc_i;
                else
                    w_new_pc = EXC_VECTOR;
            end else begin
                w_stall = stall_pattern(bus.stallreq_from_if, bus.stallreq_from_id,
                                        bus.stallreq_from_ex, bus.stallreq_from_mem);
            end
        end
    end

    assign bus.stall  = w_stall;
    assign bus.flush  = w_flush;
    assign bus.new_pc = w_new_pc;

    // COOL lasts exactly one cycle: the mem stage holds a flushed bubble then.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= CTRL_RUN;
        else if (r_state == CTRL_COOL)
            r_state <= CTRL_RUN;
        else if (w_exc_take)
            r_state <= CTRL_COOL;
    end

    assign w_run_active = (w_stall != STALL_NONE) && !w_flush;
    assign w_run_next   = !w_run_active       ? '0 :
                          (r_run_cnt == RUN_MAX) ? RUN_MAX : r_run_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run_cnt       <= '0;
            r_stall_timeout <= 1'b0;
        end else begin
            r_run_cnt <= w_run_next;
            if (w_run_next == RUN_MAX)
                r_stall_timeout <= 1'b1;
        end
    end

    assign stall_timeout = r_stall_timeout;

    pipe_ctrl_satcnt #(.W(STALL_CNT_W)) u_stall_cnt (
        .i_clk   (clk),
        .i_clr_n (rst),
        .i_inc   (w_stall[0]),
        .o_count (stall_cnt_o)
    );

    pipe_ctrl_satcnt #(.W(FLUSH_CNT_W)) u_flush_cnt (
        .i_clk   (clk),
        .i_clr_n (rst),
        .i_inc   (w_exc_take),
        .o_count (flush_cnt_o)
    );
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl with scoreboard
module tb_pipe_ctrl;
    localparam int LIMIT = 4;
    localparam int SCW   = 4;
    localparam int FCW   = 16;

    logic clk;
    logic rst;
    logic            stall_timeout;
    logic [SCW-1:0]  stall_cnt_o;
    logic [FCW-1:0]  flush_cnt_o;

    pipe_ctrl_if u_bus();

    pipe_ctrl #(
        .INT_VECTOR  (32'h0000_0020),
        .EXC_VECTOR  (32'h0000_0040),
        .STALL_LIMIT (LIMIT),
        .STALL_CNT_W (SCW),
        .FLUSH_CNT_W (FCW)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (u_bus),
        .stall_timeout (stall_timeout),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]     stall;
        logic           flush;
        logic [31:0]    new_pc;
        logic           tmo;
        logic [SCW-1:0] scnt;
        logic [FCW-1:0] fcnt;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    // Reference model state
    logic           m_cool;
    int             m_run;
    logic           m_tmo;
    logic [SCW-1:0] m_scnt;
    logic [FCW-1:0] m_fcnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] ref_stall(input logic [3:0] req);
        // req = {mem, ex, id, if}
        if (req[3])      return 6'b011111;
        else if (req[2]) return 6'b001111;
        else if (req[1]) return 6'b000111;
        else if (req[0]) return 6'b000011;
        else             return 6'b000000;
    endfunction

    task automatic model_reset();
        m_cool = 1'b0; m_run = 0; m_tmo = 1'b0; m_scnt = '0; m_fcnt = '0;
    endtask

    // One clock cycle: drive at negedge, predict, compare mid-low-phase, advance model at posedge.
    task automatic step(input string tag, input logic r, input logic [3:0] req,
                        input logic [31:0] exc, input logic [31:0] epc);
        exp_t e;
        exp_t got_e;
        logic take;
        @(negedge clk);
        rst = r;
        u_bus.stallreq_from_if  = req[0];
        u_bus.stallreq_from_id  = req[1];
        u_bus.stallreq_from_ex  = req[2];
        u_bus.stallreq_from_mem = req[3];
        u_bus.excepttype_i      = exc;
        u_bus.cp0_epc_i         = epc;
        if (!r) model_reset();
        take     = r && !m_cool && (exc != 32'h0);
        e.stall  = (!r || take) ? 6'b000000 : ref_stall(req);
        e.flush  = take;
        e.new_pc = !take ? 32'h0 : (exc == 32'h1) ? 32'h20 : (exc == 32'he) ? epc : 32'h40;
        e.tmo    = m_tmo;
        e.scnt   = m_scnt;
        e.fcnt   = m_fcnt;
        sb.push_back(e);
        #2;
        got_e = sb.pop_front();
        check({tag, ".stall"},  32'(u_bus.stall),  32'(got_e.stall));
        check({tag, ".flush"},  32'(u_bus.flush),  32'(got_e.flush));
        check({tag, ".new_pc"}, u_bus.new_pc,      got_e.new_pc);
        check({tag, ".tmo"},    32'(stall_timeout), 32'(got_e.tmo));
        check({tag, ".scnt"},   32'(stall_cnt_o),  32'(got_e.scnt));
        check({tag, ".fcnt"},   32'(flush_cnt_o),  32'(got_e.fcnt));
        @(posedge clk);
        #1;
        if (r) begin
            if (e.stall != 6'b0 && !e.flush)
                m_run = (m_run >= LIMIT) ? LIMIT : m_run + 1;
            else
                m_run = 0;
            if (m_run == LIMIT) m_tmo = 1'b1;
            if (e.stall[0] && m_scnt != {SCW{1'b1}}) m_scnt = m_scnt + 1'b1;
            if (take && m_fcnt != {FCW{1'b1}}) m_fcnt = m_fcnt + 1'b1;
            m_cool = take;
        end
    endtask

    localparam logic [3:0] R_NONE = 4'b0000;
    localparam logic [3:0] R_IF   = 4'b0001;
    localparam logic [3:0] R_ID   = 4'b0010;
    localparam logic [3:0] R_IDEX = 4'b0110;
    localparam logic [3:0] R_MEM  = 4'b1000;
    localparam logic [3:0] R_ALL  = 4'b1110;

    initial begin
        rst = 1'b0;
        u_bus.stallreq_from_if  = 1'b0;
        u_bus.stallreq_from_id  = 1'b0;
        u_bus.stallreq_from_ex  = 1'b0;
        u_bus.stallreq_from_mem = 1'b1;
        u_bus.excepttype_i      = 32'h0;
        u_bus.cp0_epc_i         = 32'h0;
        model_reset();

        // Reset holds outputs quiet despite a mem request
        step("rst0", 1'b0, R_MEM, 32'h0, 32'h0);
        step("rst1", 1'b0, R_MEM, 32'h1, 32'h0);
        step("rel",  1'b1, R_MEM, 32'h0, 32'h0);

        // Priority
        step("idex", 1'b1, R_IDEX, 32'h0, 32'h0);
        step("none", 1'b1, R_NONE, 32'h0, 32'h0);
        step("all",  1'b1, R_ALL,  32'h0, 32'h0);
        step("if",   1'b1, R_IF,   32'h0, 32'h0);
        step("none", 1'b1, R_NONE, 32'h0, 32'h0);

        // Interrupt during stall, stale code in COOL, then general exception
        step("int",  1'b1, R_MEM, 32'h1, 32'h0);
        step("cool", 1'b1, R_MEM, 32'h8, 32'h0);
        step("exc8", 1'b1, R_MEM, 32'h8, 32'h0);
        check("flush_cnt2", 32'(flush_cnt_o), 32'd2);

        // ERET and unknown code
        step("cool", 1'b1, R_NONE, 32'h0, 32'h0);
        step("eret", 1'b1, R_NONE, 32'he, 32'h0000_1234);
        step("cool", 1'b1, R_NONE, 32'h0, 32'h0);
        step("exc5", 1'b1, R_IF,   32'h5, 32'h0000_1234);
        step("cool", 1'b1, R_NONE, 32'h0, 32'h0);
        step("none", 1'b1, R_NONE, 32'h0, 32'h0);

        // Watchdog: 3 stalled cycles do not trip
        for (int i = 0; i < 3; i++) step("wd3", 1'b1, R_ID, 32'h0, 32'h0);
        step("wd3d", 1'b1, R_NONE, 32'h0, 32'h0);
        check("wd_no_trip", 32'(stall_timeout), 32'd0);

        // Exception in a stall run clears the count
        step("wdx", 1'b1, R_ID, 32'h0, 32'h0);
        step("wdx", 1'b1, R_ID, 32'h0, 32'h0);
        step("wdx", 1'b1, R_ID, 32'h8, 32'h0);
        for (int i = 0; i < 3; i++) step("wdx", 1'b1, R_ID, 32'h0, 32'h0);
        step("wdxd", 1'b1, R_NONE, 32'h0, 32'h0);
        check("wd_exc_clr", 32'(stall_timeout), 32'd0);

        // 4 stalled cycles trip and the flag sticks
        for (int i = 0; i < 4; i++) step("wd4", 1'b1, R_ID, 32'h0, 32'h0);
        check("wd_trip", 32'(stall_timeout), 32'd1);
        step("wd4d", 1'b1, R_NONE, 32'h0, 32'h0);
        check("wd_sticky", 32'(stall_timeout), 32'd1);

        // Reset mid-COOL, first cycle after release is RUN
        step("int2",  1'b1, R_NONE, 32'h1, 32'h0);
        step("rstc",  1'b0, R_MEM,  32'h1, 32'h0);
        check("rst_tmo", 32'(stall_timeout), 32'd0);
        step("relx",  1'b1, R_MEM,  32'h1, 32'h0);
        step("cool",  1'b1, R_MEM,  32'h0, 32'h0);

        // Reset mid-stall, then saturation of the stall counter
        step("rsts",  1'b0, R_MEM,  32'h0, 32'h0);
        for (int i = 0; i < 20; i++) step("sat", 1'b1, R_MEM, 32'h0, 32'h0);
        check("sat_cnt", 32'(stall_cnt_o), 32'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the five-stage CPU. It merges per-stage stall requests into the 6-bit stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb. It turns the memory-stage exception type into a one-cycle flush plus a redirect PC. Sequential state covers post-flush exception masking, a stall watchdog and saturating performance counters.

Parameters:
INT_VECTOR, 32'h00000020, redirect target for interrupts
EXC_VECTOR, 32'h00000040, redirect target for all other non-ERET exceptions
STALL_LIMIT, 16, consecutive stalled cycles that trip the watchdog (>=2)
STALL_CNT_W, 32, width of stall-cycle performance counter
FLUSH_CNT_W, 16, width of flush performance counter

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  asynchronous, active-low reset
stallreq_from_if  input  1  fetch stage requests stall
stallreq_from_id  input  1  decode stage requests stall
stallreq_from_ex  input  1  execute stage requests stall (mult/div, madd/msub)
stallreq_from_mem  input  1  memory stage requests stall
excepttype_i  input  32  exception type from mem stage, 0 = none
cp0_epc_i  input  32  current EPC from CP0 (already forwarded)
stall  output  6  [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb, 1=Stop
flush  output  1  flush all pipeline registers this cycle
new_pc  output  32  redirect target, valid when flush=1
stall_timeout  output  1  sticky watchdog flag
stall_cnt_o  output  STALL_CNT_W  cycles with stall[0]=1, saturating
flush_cnt_o  output  FLUSH_CNT_W  flushes issued, saturating

Behaviour:
- Reset (rst=0, async): state=RUN, run counter=0, stall_timeout=0, stall_cnt_o=0, flush_cnt_o=0. Combinational outputs are forced to stall=6'b000000, flush=0, new_pc=0 while rst=0.
- stall, flush and new_pc are combinational from inputs and state (same-cycle), so the pipeline registers act on the edge ending this cycle.
- exc_take = (state==RUN) && (excepttype_i!=0).
- When exc_take=1:
  - flush=1 and stall=6'b000000, regardless of any stall request.
  - new_pc: 32'h1 -> INT_VECTOR; 32'he -> cp0_epc_i; any other nonzero -> EXC_VECTOR.
- When exc_take=0, flush=0 and new_pc=0. stall is set by priority:
  - mem request -> 6'b011111
  - else ex -> 6'b001111
  - else id -> 6'b000111
  - else if -> 6'b000011
  - else 6'b000000
- FSM has two states, RUN and COOL.
  - RUN -> COOL on exc_take.
  - COOL -> RUN unconditionally after one cycle.
  - In COOL, excepttype_i is ignored: the mem stage holds a flushed bubble, and any value seen there is stale.
- Watchdog:
  - The run counter increments each cycle with stall!=0 && flush==0. It clears on any cycle with stall==0 or flush==1, and saturates at STALL_LIMIT.
  - stall_timeout sets on the edge where the counter reaches STALL_LIMIT. It stays set until reset.
- stall_cnt_o increments on each cycle with stall[0]=1 and holds at all-ones.
- flush_cnt_o increments on each exc_take and holds at all-ones.
- Reset asserted mid-stall or mid-COOL returns everything to the reset values immediately. The first cycle after release is RUN.

Decomposition:
- defines.v gains the following:
  - ExcInterrupt=32'h1 and ExcEret=32'he.
  - Stall pattern constants StallMem, StallEx, StallId, StallIf, StallNone.
  - State encodings CtrlRun and CtrlCool.
  - Reuse the existing Stop/NoStop defines.
- One sub-module, pipe_ctrl_satcnt: a parameterised-width saturating counter with inc and async active-low clear. It is instantiated twice, for the stall and flush counters.

Test Plan:
- Reset: hold rst=0 with stallreq_from_mem=1 -> stall=000000, flush=0, all counters 0. Release -> stall=011111 on the next cycle.
- Priority: id+ex requests -> stall=001111; add mem -> 011111; only if -> 000011; none -> 000000.
- Interrupt with stall: excepttype_i=32'h1 and stallreq_from_mem=1 -> same cycle flush=1, stall=000000, new_pc=32'h20. The next cycle applies excepttype_i=32'h8 -> flush=0 (COOL). The cycle after that -> flush=1, new_pc=32'h40, flush_cnt_o=2.
- ERET: excepttype_i=32'he, cp0_epc_i=32'h00001234 -> flush=1, new_pc=32'h00001234. Unknown code 32'h5 -> new_pc=32'h40.
- Watchdog with STALL_LIMIT=4:
  - Hold stallreq_from_id for 3 cycles, then drop it -> stall_timeout stays 0.
  - Hold it for 4 cycles -> stall_timeout=1 after the 4th edge, and it stays 1 after the request drops.
  - An exception during a stall run clears the count.
- Saturation with STALL_CNT_W=4: 20 consecutive stalled cycles -> stall_cnt_o=4'hF, with no wrap.
